tone_generator_accum: RTL and testbench
=======================================

Name: tone_generator_accum

Overview:
Per-voice phase accumulator. It sits directly upstream of the noise tone generator and the other waveform generators. It advances a 24-bit phase by a frequency word on each sample-enable. It produces:
- a one-cycle noise_tick strobe, used as the noise LFSR clock enable, on each rising edge of accumulator bit NOISE_BIT;
- a noise_rst level, driven by the test bit;
- a hard-sync strobe for the next voice;
- a pulse-width comparator output.

Parameters:
FREQ_WIDTH, 16, width of frequency word; zero-extended into the accumulator
ACC_WIDTH, 24, accumulator width; must be >= FREQ_WIDTH and >= 12
NOISE_BIT, 19, accumulator bit whose 0->1 transition generates noise_tick; must be < ACC_WIDTH

Ports:
clk  input  1  system clock; all logic on rising edge
rst  input  1  reset, synchronous, active-low (rst==0 resets on the next clk edge)
en  input  1  sample enable; accumulator updates only on cycles with en==1
freq  input  FREQ_WIDTH  phase increment per enabled cycle
pw  input  12  pulse width threshold
test  input  1  test bit; holds accumulator at 0
sync_in  input  1  hard-sync strobe from the source voice's sync_out
acc_out  output  ACC_WIDTH  current accumulator value (registered)
noise_tick  output  1  one-cycle strobe to the noise generator
noise_rst  output  1  registered copy of test; drives noise generator reset
sync_out  output  1  one-cycle strobe on accumulator MSB 0->1
pulse_out  output  1  registered pulse waveform bit

Behaviour:
- Reset (rst==0 at a clk edge): acc_out=0, noise_tick=0, sync_out=0, noise_rst=0, pulse_out=0. Reset overrides all inputs, including mid-count.
- Per clk edge with rst==1, evaluated in priority order:
  1. test==1: acc<=0; noise_tick<=0; sync_out<=0. Applies regardless of en.
  2. en==0: acc holds; noise_tick<=0; sync_out<=0.
  3. en==1 and sync_in==1 (sync enabled, see Optional Feature): acc<=0; noise_tick<=0; sync_out<=0.
  4. en==1 otherwise: next = (acc + zero-extended freq) mod 2^ACC_WIDTH; acc<=next.
     - noise_tick <= ~acc[NOISE_BIT] & next[NOISE_BIT]
     - sync_out <= ~acc[MSB] & next[MSB]
- Latency and width of strobes:
  - Strobes are registered on the same edge as the acc update, so they coincide with the new acc_out value.
  - Strobes are exactly one clk wide, even if en stays high.
- noise_rst <= test every cycle (1-cycle latency). It is held high for as long as test is high.
- pulse_out <= test | (acc[ACC_WIDTH-1 -: 12] >= pw), evaluated every clk.
  - Lags acc_out by one cycle.
  - pw==0 gives a constant 1.
- Boundary cases:
  - Wrap-around: overflow is silently modular. A 1->0 MSB transition gives no strobe.
  - Wrapping past 0 can still produce a NOISE_BIT rise in the same update.
  - freq==0: acc holds; no strobes.
  - sync_in while en==0: ignored (not latched).
  - sync_in on the same update where MSB/NOISE_BIT would rise: sync wins; acc=0; no strobes.
  - test released: counting resumes from 0 on the next en cycle.

Optional Feature:
TONE_ACCUM_SYNC_EN
- Defined: hard sync active as described (priority 3).
- Undefined: the sync_in port still exists but is ignored. Priority 3 is removed, so en==1 always adds freq. sync_out is still generated.

Test Plan:
1. Reset: rst=0 for 2 cycles with en=1, freq=0x1234, test=0 -> acc_out=0, noise_tick=0, sync_out=0, pulse_out=0, noise_rst=0. Then rst=1 -> acc_out=0x001234 after the first edge.
2. Free run: freq=0x1000, en=1 constant from acc=0.
   - noise_tick high only on the edge of update 128 (acc_out=0x080000), then again at 0x180000.
   - sync_out high only at update 2048 (acc_out=0x800000).
   - No other strobes.
3. Gated enable: freq=0x1000, en=1 on alternate cycles -> acc_out=0x080000 after 128 enabled cycles (256 clocks); noise_tick exactly one clk wide; acc holds on en=0 cycles.
4. Test bit: after 100 updates (acc=0x064000), assert test for 5 cycles.
   - Next edge: acc_out=0; noise_rst high one cycle later; pulse_out=1; no strobes.
   - Release test: acc_out=0x1000 after the next en edge.
5. Hard sync with TONE_ACCUM_SYNC_EN: freq=0x0100, acc=0x123400, sync_in=1 with en=1 -> acc_out=0.
   - Macro undefined: acc_out=0x123500.
   - sync_in with en=0 -> acc holds.
6. Wrap and pulse: freq=0xFFFF, pw=0x800.
   - Update 128: acc=0x7FFF80, sync_out=0.
   - Update 129: acc=0x80FF7F, sync_out=1; pulse_out goes high the following cycle.
   - Update 257: acc=0x00FEFF, pulse_out low the following cycle.

Source files
------------

// File: rtl/tone_generator_accum_if.sv
// Control and status bundle for one voice's phase accumulator.
// The master drives the per-voice controls; the slave is the accumulator itself.
interface tone_generator_accum_if #(
  parameter int FREQ_WIDTH = 16,
  parameter int ACC_WIDTH  = 24
);
  logic                  en;
  logic [FREQ_WIDTH-1:0] freq;
  logic [11:0]           pw;
  logic                  test;
  logic                  sync_in;
  logic [ACC_WIDTH-1:0]  acc_out;
  logic                  noise_tick;
  logic                  noise_rst;
  logic                  sync_out;
  logic                  pulse_out;

  modport master (
    output en, freq, pw, test, sync_in,
    input  acc_out, noise_tick, noise_rst, sync_out, pulse_out
  );

  modport slave (
    input  en, freq, pw, test, sync_in,
    output acc_out, noise_tick, noise_rst, sync_out, pulse_out
  );
endinterface

// File: rtl/tone_generator_accum.sv
// Per-voice phase accumulator with noise-clock, hard-sync and pulse-compare outputs.
// Define TONE_ACCUM_SYNC_EN to let sync_in reset the phase; otherwise sync_in is ignored.
module tone_generator_accum #(
  parameter int FREQ_WIDTH = 16,
  parameter int ACC_WIDTH  = 24,
  parameter int NOISE_BIT  = 19
) (
  input logic                   clk,
  input logic                   rst,
  tone_generator_accum_if.slave bus
);
  localparam int MSB = ACC_WIDTH - 1;

  logic [ACC_WIDTH-1:0] acc_q, acc_d, sum;
  logic                 noise_tick_q, noise_tick_d;
  logic                 sync_out_q, sync_out_d;
  logic                 noise_rst_q;
  logic                 pulse_q, pulse_d;
  logic                 sync_hit;

`ifdef TONE_ACCUM_SYNC_EN
  assign sync_hit = bus.sync_in;
`else
  logic unused_sync_in;
  assign unused_sync_in = bus.sync_in;
  assign sync_hit       = 1'b0;
`endif

  // Modular add: overflow simply wraps, which is what keeps the phase periodic.
  assign sum = acc_q + ACC_WIDTH'(bus.freq);

  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves
    // a value unassigned, which would otherwise infer a latch.
    acc_d        = acc_q;
    noise_tick_d = 1'b0;
    sync_out_d   = 1'b0;
    if (bus.test) begin
      acc_d = '0;
    end else if (bus.en) begin
      if (sync_hit) begin
        acc_d = '0;
      end else begin
        acc_d        = sum;
        noise_tick_d = ~acc_q[NOISE_BIT] & sum[NOISE_BIT];
        sync_out_d   = ~acc_q[MSB] & sum[MSB];
      end
    end
  end

  // Compares the phase as it stood before this edge, so pulse_out trails acc_out by one cycle.
  assign pulse_d = bus.test | (acc_q[MSB -: 12] >= bus.pw);

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (!rst) begin
      acc_q        <= '0;
      noise_tick_q <= 1'b0;
      sync_out_q   <= 1'b0;
      noise_rst_q  <= 1'b0;
      pulse_q      <= 1'b0;
    end else begin
      acc_q        <= acc_d;
      noise_tick_q <= noise_tick_d;
      sync_out_q   <= sync_out_d;
      noise_rst_q  <= bus.test;
      pulse_q      <= pulse_d;
    end
  end

  assign bus.acc_out    = acc_q;
  assign bus.noise_tick = noise_tick_q;
  assign bus.sync_out   = sync_out_q;
  assign bus.noise_rst  = noise_rst_q;
  assign bus.pulse_out  = pulse_q;
endmodule

// File: tb/tb_tone_generator_accum.sv
// Self-checking bench for tone_generator_accum: arithmetic reference model compared
// every cycle, plus directed scenarios with hand-computed phase values.
module tb_tone_generator_accum;
  localparam longint ACC_MOD   = 64'd1 << 24;
  localparam longint NOISE_DIV = 64'd1 << 19;
  localparam longint HALF      = 64'd1 << 23;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  tone_generator_accum_if #(.FREQ_WIDTH(16), .ACC_WIDTH(24)) bus ();

  tone_generator_accum #(.FREQ_WIDTH(16), .ACC_WIDTH(24), .NOISE_BIT(19)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: phase as an integer, strobes from which half-periods the phase crosses.
  longint m_acc   = 0;
  bit     m_nt    = 0;
  bit     m_sync  = 0;
  bit     m_nrst  = 0;
  bit     m_pulse = 0;
  bit     m_valid = 0;

  always @(posedge clk) begin
    longint nxt;
    if (!rst) begin
      m_acc = 0; m_nt = 0; m_sync = 0; m_nrst = 0; m_pulse = 0;
      m_valid = 1;
    end else begin
      m_pulse = bus.test || ((m_acc / 4096) >= longint'(bus.pw));
      m_nrst  = bus.test;
      m_nt    = 0;
      m_sync  = 0;
      if (bus.test) begin
        m_acc = 0;
      end else if (bus.en) begin
`ifdef TONE_ACCUM_SYNC_EN
        if (bus.sync_in) m_acc = 0;
        else begin
`else
        begin
`endif
          nxt    = (m_acc + longint'(bus.freq)) % ACC_MOD;
          m_nt   = ((m_acc / NOISE_DIV) % 2 == 0) && ((nxt / NOISE_DIV) % 2 == 1);
          m_sync = (m_acc < HALF) && (nxt >= HALF);
          m_acc  = nxt;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      check("model acc_out",    32'(bus.acc_out),  32'(m_acc));
      check("model noise_tick", 32'(bus.noise_tick), 32'(m_nt));
      check("model sync_out",   32'(bus.sync_out),   32'(m_sync));
      check("model noise_rst",  32'(bus.noise_rst),  32'(m_nrst));
      check("model pulse_out",  32'(bus.pulse_out),  32'(m_pulse));
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    rst = 1'b1;
  endtask

  int nt_cnt;
  int sy_cnt;

  initial begin
    bus.en = 1'b1; bus.freq = 16'h1234; bus.pw = 12'h800;
    bus.test = 1'b0; bus.sync_in = 1'b0;

    // Reset holds everything at zero despite en and freq being active.
    tick(2);
    check("reset acc_out",    32'(bus.acc_out), 32'h0);
    check("reset noise_tick", 32'(bus.noise_tick), 32'h0);
    check("reset sync_out",   32'(bus.sync_out), 32'h0);
    check("reset noise_rst",  32'(bus.noise_rst), 32'h0);
    check("reset pulse_out",  32'(bus.pulse_out), 32'h0);
    rst = 1'b1;
    tick();
    check("first update", 32'(bus.acc_out), 32'h001234);

    // Free run: noise ticks at every odd multiple of 0x080000, one sync at 0x800000.
    do_reset();
    bus.freq = 16'h1000;
    nt_cnt = 0; sy_cnt = 0;
    for (int i = 1; i <= 2048; i++) begin
      tick();
      if (bus.noise_tick) nt_cnt++;
      if (bus.sync_out) sy_cnt++;
      if (i == 128) begin
        check("run acc@128", 32'(bus.acc_out), 32'h080000);
        check("run tick@128", 32'(bus.noise_tick), 32'h1);
      end
      if (i == 129) check("run tick@129", 32'(bus.noise_tick), 32'h0);
      if (i == 384) begin
        check("run acc@384", 32'(bus.acc_out), 32'h180000);
        check("run tick@384", 32'(bus.noise_tick), 32'h1);
      end
    end
    check("run acc@2048",  32'(bus.acc_out), 32'h800000);
    check("run sync@2048", 32'(bus.sync_out), 32'h1);
    check("run tick count", 32'(nt_cnt), 32'd8);
    check("run sync count", 32'(sy_cnt), 32'd1);

    // Alternate-cycle enable: 128 updates over 256 clocks, strobe still one clock wide.
    do_reset();
    nt_cnt = 0;
    for (int i = 0; i < 256; i++) begin
      bus.en = (i % 2 == 0);
      tick();
      if (bus.noise_tick) nt_cnt++;
    end
    check("gated acc", 32'(bus.acc_out), 32'h080000);
    check("gated tick count", 32'(nt_cnt), 32'd1);
    bus.en = 1'b1;

    // Test bit clears the phase, forces pulse and noise reset, counting resumes from 0.
    do_reset();
    tick(100);
    check("pre-test acc", 32'(bus.acc_out), 32'h064000);
    bus.test = 1'b1;
    tick();
    check("test acc",       32'(bus.acc_out), 32'h0);
    check("test noise_rst", 32'(bus.noise_rst), 32'h1);
    check("test pulse_out", 32'(bus.pulse_out), 32'h1);
    tick(4);
    check("test held acc", 32'(bus.acc_out), 32'h0);
    bus.test = 1'b0;
    tick();
    check("test release acc",       32'(bus.acc_out), 32'h001000);
    check("test release noise_rst", 32'(bus.noise_rst), 32'h0);

    // Hard sync: ignored while en is low, clears the phase when enabled (if built in).
    do_reset();
    bus.freq = 16'h1234;
    tick(256);
    check("sync pre acc", 32'(bus.acc_out), 32'h123400);
    bus.freq = 16'h0100; bus.sync_in = 1'b1; bus.en = 1'b0;
    tick();
    check("sync en0 hold", 32'(bus.acc_out), 32'h123400);
    bus.en = 1'b1;
    tick();
`ifdef TONE_ACCUM_SYNC_EN
    check("sync acc", 32'(bus.acc_out), 32'h0);
`else
    check("sync ignored acc", 32'(bus.acc_out), 32'h123500);
`endif
    bus.sync_in = 1'b0;
    tick();

    // Wrap and pulse compare against pw = 0x800.
    do_reset();
    bus.freq = 16'hFFFF; bus.pw = 12'h800;
    tick(128);
    check("wrap acc@128",  32'(bus.acc_out), 32'h7FFF80);
    check("wrap sync@128", 32'(bus.sync_out), 32'h0);
    tick();
    check("wrap acc@129",   32'(bus.acc_out), 32'h80FF7F);
    check("wrap sync@129",  32'(bus.sync_out), 32'h1);
    check("wrap pulse@129", 32'(bus.pulse_out), 32'h0);
    tick();
    check("wrap pulse@130", 32'(bus.pulse_out), 32'h1);
    check("wrap sync@130",  32'(bus.sync_out), 32'h0);
    tick(127);
    check("wrap acc@257",   32'(bus.acc_out), 32'h00FEFF);
    check("wrap pulse@257", 32'(bus.pulse_out), 32'h1);
    check("wrap no sync on fall", 32'(bus.sync_out), 32'h0);
    tick();
    check("wrap pulse@258", 32'(bus.pulse_out), 32'h0);
    bus.pw = 12'h000;
    tick();
    check("pw0 pulse", 32'(bus.pulse_out), 32'h1);
    check("pw0 acc@259", 32'(bus.acc_out), 32'h02FEFD);
    bus.freq = 16'h0000;
    tick(3);
    check("freq0 hold", 32'(bus.acc_out), 32'h02FEFD);

    // Reset in the middle of a count.
    bus.freq = 16'h4321;
    tick(5);
    rst = 1'b0;
    tick();
    check("mid reset acc",   32'(bus.acc_out), 32'h0);
    check("mid reset pulse", 32'(bus.pulse_out), 32'h0);
    rst = 1'b1;
    tick(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
